register_file: RTL and testbench
================================

# register_file

Integer register file for the 32-bit RISC-V core: 32 general-purpose registers x0–x31, each 32 bits wide. It has two combinational read ports and one synchronous write port. It sits between decode, which supplies rs1/rs2 addresses, and writeback, which supplies the rd address, data and enable. x0 is hardwired to zero, as the RISC-V ISA requires.

## Interface
Parameters:
- XLEN, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register address width (log2 NUM_REGS).

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset; clears every register.
- read_addr1  input  ADDR_W  read port 1 address (rs1).
- read_addr2  input  ADDR_W  read port 2 address (rs2).
- write_addr  input  ADDR_W  write address (rd).
- write_data  input  XLEN  data to write.
- write_enable  input  1  write strobe; sampled at the rising edge of clk.
- read_data1  output  XLEN  contents of register read_addr1.
- read_data2  output  XLEN  contents of register read_addr2.

## Operation
- Storage: NUM_REGS x XLEN flip-flop array.
- Reset: on a rising edge with rst=1, all registers become 0.
  - Reset has priority over write; write_enable is ignored while rst=1.
- Write: on a rising edge with rst=0 and write_enable=1, write_data is stored in register[write_addr].
  - If write_addr=0, the write is discarded and x0 stays 0.
- Read: read_dataN = register[read_addrN], purely combinational.
  - read_addrN=0 always returns 0, regardless of any write attempt.
- Both read ports are independent and may address the same register simultaneously.
- No write-to-read bypass: a read of the register being written returns the old value until the clock edge, then the new value.
- Inputs that are X on unused addresses need no special handling. Addresses are always in range because ADDR_W covers NUM_REGS exactly.

## Timing
- Read latency: 0 cycles (combinational from address and array state).
- Write latency: 1 edge. Data is visible on a read port immediately after the rising edge that captured it.
- Reset latency: 1 edge. Before the first reset edge, register contents are undefined, except x0, which reads 0.
- After reset, read_data1 and read_data2 are 0 for every address.
- Reset asserted mid-operation clears the array at the next edge. A write presented on that same edge is lost.
- Simultaneous read and write of the same address: the read shows the pre-edge value during the cycle and the post-edge value after it.

## Structure
- Shared core package holds:
  - XLEN=32, NUM_REGS=32, REG_ADDR_W=5.
  - Constant REG_ZERO=5'd0.
- No sub-module is needed. A single always block handles reset and write, plus two continuous read assigns with x0 masking.

## Test plan
- Reset: rst=1 for one edge, then rst=0. Read addresses 6 and 1 give read_data1=0 and read_data2=0.
- Basic write: write_enable=1, write_addr=2, write_data=0x00000008, one edge. Then read_addr1=2 gives 0x00000008.
- x0 protection: write_enable=1, write_addr=0, write_data=0x00000008, one edge. Then read_addr1=0 gives 0.
- Reset priority: rst=1, write_enable=1, write_addr=1, write_data=0x00000018, one edge. Then with rst=0, read_addr1=1 gives 0. Repeat with rst=0 and read 0x00000018.
- Dual read and no bypass:
  - Preload x4=0xDEADBEEF and x5=0x12345678, then read both ports simultaneously and get both values.
  - Next, drive write_addr=4 with data 0xCAFEF00D and enable=1. Before the edge, read_data1 (addr 4) stays 0xDEADBEEF; after the edge it reads 0xCAFEF00D.
- Write disabled: write_enable=0, write_addr=5, data=0xFFFFFFFF, one edge. x5 still reads 0x12345678.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared core constants for the integer register file: widths, register count
// and the hardwired-zero register index.
package register_file_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file.sv
// RV32 integer register file: two combinational read ports, one synchronous
// write port, x0 hardwired to zero on both the write and read paths.
module register_file #(
  parameter int unsigned XLEN     = register_file_pkg::XLEN,
  parameter int unsigned NUM_REGS = register_file_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = register_file_pkg::REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [XLEN-1:0]   write_data,
  input  logic              write_enable,
  output logic [XLEN-1:0]   read_data1,
  output logic [XLEN-1:0]   read_data2
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(register_file_pkg::REG_ZERO);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            w_wr_en;

  // Writes to x0 are dropped here so the array never holds a stale x0 value.
  assign w_wr_en = write_enable && (write_addr != ZERO_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[write_addr] <= write_data;
    end
  end

  // Read-side masking keeps x0 at zero even before the first reset edge.
  assign read_data1 = (read_addr1 == ZERO_ADDR) ? '0 : r_regs[read_addr1];
  assign read_data2 = (read_addr2 == ZERO_ADDR) ? '0 : r_regs[read_addr2];

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by
// randomized traffic checked against an array-based reference model.
module tb_register_file;
  import register_file_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [REG_ADDR_W-1:0] ra1, ra2, wa;
  logic [XLEN-1:0]       wd;
  logic                  we;
  logic [XLEN-1:0]       rd1, rd2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [XLEN-1:0] model [NUM_REGS];

  register_file #(
    .XLEN    (XLEN),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (REG_ADDR_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .read_addr1  (ra1),
    .read_addr2  (ra2),
    .write_addr  (wa),
    .write_data  (wd),
    .write_enable(we),
    .read_data1  (rd1),
    .read_data2  (rd2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [XLEN-1:0] expect_read(input logic [REG_ADDR_W-1:0] a);
    return (a == 0) ? '0 : model[a];
  endfunction

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the architectural effect of the upcoming edge to the model, then
  // advance past the edge.
  task automatic clock_edge();
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = 'x;
    rst = 1'b0; we = 1'b0; ra1 = '0; ra2 = '0; wa = '0; wd = '0;
    #2;
    check("x0_before_reset_p1", rd1, '0);
    check("x0_before_reset_p2", rd2, '0);

    rst = 1'b1;
    clock_edge();
    rst = 1'b0;
    ra1 = 5'd6; ra2 = 5'd1;
    #1;
    check("reset_rd1_addr6", rd1, 32'h0);
    check("reset_rd2_addr1", rd2, 32'h0);
    for (int i = 0; i < NUM_REGS; i++) begin
      ra1 = REG_ADDR_W'(i); ra2 = REG_ADDR_W'(NUM_REGS - 1 - i);
      #1;
      check("reset_sweep_p1", rd1, 32'h0);
      check("reset_sweep_p2", rd2, 32'h0);
    end

    we = 1'b1; wa = 5'd2; wd = 32'h0000_0008;
    clock_edge();
    we = 1'b0; ra1 = 5'd2;
    #1;
    check("basic_write_x2", rd1, 32'h0000_0008);

    we = 1'b1; wa = 5'd0; wd = 32'h0000_0008;
    clock_edge();
    we = 1'b0; ra1 = 5'd0;
    #1;
    check("x0_write_discard", rd1, 32'h0);

    rst = 1'b1; we = 1'b1; wa = 5'd1; wd = 32'h0000_0018;
    clock_edge();
    rst = 1'b0; we = 1'b0; ra1 = 5'd1; ra2 = 5'd2;
    #1;
    check("reset_priority_x1", rd1, 32'h0);
    check("reset_clears_x2", rd2, 32'h0);
    we = 1'b1;
    clock_edge();
    we = 1'b0;
    #1;
    check("write_after_reset_x1", rd1, 32'h0000_0018);

    we = 1'b1; wa = 5'd4; wd = 32'hDEAD_BEEF;
    clock_edge();
    wa = 5'd5; wd = 32'h1234_5678;
    clock_edge();
    we = 1'b0; ra1 = 5'd4; ra2 = 5'd5;
    #1;
    check("dual_read_x4", rd1, 32'hDEAD_BEEF);
    check("dual_read_x5", rd2, 32'h1234_5678);
    ra2 = 5'd4;
    #1;
    check("same_reg_both_ports", rd2, 32'hDEAD_BEEF);

    we = 1'b1; wa = 5'd4; wd = 32'hCAFE_F00D; ra1 = 5'd4;
    #1;
    check("no_bypass_pre_edge", rd1, 32'hDEAD_BEEF);
    clock_edge();
    we = 1'b0;
    #1;
    check("post_edge_new_value", rd1, 32'hCAFE_F00D);

    we = 1'b0; wa = 5'd5; wd = 32'hFFFF_FFFF;
    clock_edge();
    ra2 = 5'd5;
    #1;
    check("write_disabled_x5", rd2, 32'h1234_5678);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 3) != 0);
      wa  = REG_ADDR_W'($urandom_range(0, NUM_REGS - 1));
      wd  = $urandom;
      ra1 = ($urandom_range(0, 2) == 0) ? wa : REG_ADDR_W'($urandom_range(0, NUM_REGS - 1));
      ra2 = REG_ADDR_W'($urandom_range(0, NUM_REGS - 1));
      #1;
      check("rand_pre_p1", rd1, expect_read(ra1));
      check("rand_pre_p2", rd2, expect_read(ra2));
      clock_edge();
      rst = 1'b0; we = 1'b0;
      #1;
      check("rand_post_p1", rd1, expect_read(ra1));
      check("rand_post_p2", rd2, expect_read(ra2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
